// File: rtl/serial_tx_port_pkg.sv
// serial_tx_port_pkg: shared FSM encoding and frame constants for the serial transmitter
package serial_tx_port_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;
    localparam int START_BITS = 1;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;
    localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/serial_tx_port_fifo.sv
// tx_fifo: small circular byte FIFO with combinational head output
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    // a push while full is dropped even if a pop happens in the same cycle
    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wp + AW'(do_push);
            rp  <= rp + AW'(do_pop);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/serial_tx_port.sv
// serial_tx_port: CPU byte FIFO feeding an 8N1 serial transmitter
module serial_tx_port
    import serial_tx_port_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [7:0] wd,
    input  logic       clr_ovf,
    output logic       txd,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       ovf
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    logic [1:0] state;
    logic [BW-1:0] baud;
    logic [2:0] bit_idx;
    logic [7:0] shift, dout;
    logic bit_end, pop;
    assign bit_end = baud == BAUD_LAST;
    // STOP pops on its last cycle so the next start bit follows without a gap
    assign pop  = !empty && (state == S_IDLE || (state == S_STOP && bit_end));
    assign busy = state != S_IDLE;
    tx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (we),
        .pop   (pop),
        .din   (wd),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= IDLE_LEVEL;
        end else begin
            baud <= (state == S_IDLE || bit_end) ? '0 : baud + 1'b1;
            case (state)
                S_IDLE:
                    if (pop) begin
                        state <= S_START;
                        shift <= dout;
                        txd   <= 1'b0;
                    end
                S_START:
                    if (bit_end) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                        txd     <= shift[0];
                    end
                S_DATA:
                    if (bit_end) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        state   <= (bit_idx == 3'(DATA_BITS - 1)) ? S_STOP : S_DATA;
                        txd     <= (bit_idx == 3'(DATA_BITS - 1)) ? IDLE_LEVEL : shift[1];
                    end
                S_STOP:
                    if (bit_end) begin
                        state <= pop ? S_START : S_IDLE;
                        shift <= pop ? dout : shift;
                        txd   <= pop ? 1'b0 : IDLE_LEVEL;
                    end
                default: state <= S_IDLE;
            endcase
        end
    always_ff @(posedge clk or posedge reset)
        if (reset) ovf <= 1'b0;
        else if (we && full) ovf <= 1'b1;
        else if (clr_ovf) ovf <= 1'b0;
endmodule

// File: tb/tb_serial_tx_port.sv
// tb_serial_tx_port: directed and random stimulus against a frame-timing reference model
module tb_serial_tx_port;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int FL    = 10 * CPB;
    logic clk = 1'b0, reset = 1'b1, we = 1'b0, clr_ovf = 1'b0;
    logic [7:0] wd = 8'h00;
    logic txd, full, empty, busy, ovf;
    int n_assert = 0, n_fail = 0;
    logic [7:0] q[$];
    logic [7:0] cur = 8'h00;
    int cur_start = 0, e = 0, cap_i = -1;
    bit active = 0, m_ovf = 0;
    logic [39:0] cap = '0;
    logic [9:0] a5_slots;

    serial_tx_port #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .we(we), .wd(wd), .clr_ovf(clr_ovf),
        .txd(txd), .full(full), .empty(empty), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, e);
        end
    endtask

    // line level from the current frame's start time: start bit, 8 data LSB first, stop bit
    function automatic logic exp_txd();
        int j;
        if (!active) return 1'b1;
        j = (e - cur_start) / CPB;
        return (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : cur[j-1];
    endfunction

    task automatic step(input logic w, input logic [7:0] d, input logic c);
        bit free, pop, drop;
        @(negedge clk);
        we = w; wd = d; clr_ovf = c;
        @(posedge clk);
        e++;
        free = !active || e >= cur_start + FL;
        drop = w && q.size() == DEPTH;
        pop  = free && q.size() > 0;
        if (free) active = 0;
        if (pop) begin
            cur = q.pop_front();
            cur_start = e;
            active = 1;
        end
        if (w && !drop) q.push_back(d);
        if (drop) m_ovf = 1;
        else if (c) m_ovf = 0;
        #1;
        chk("txd", txd, exp_txd());
        chk("busy", busy, active);
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEPTH);
        chk("ovf", ovf, m_ovf);
        if (cap_i >= 0 && cap_i < 40) begin
            cap[cap_i] = txd;
            cap_i++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        a5_slots = 10'b1101001010;
        #12;
        chk("rst_txd", txd, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle(50);
        // single 0xA5 frame, captured slot by slot
        step(1'b1, 8'hA5, 1'b0);
        cap_i = 0;
        idle(45);
        for (int i = 0; i < 40; i++) chk("a5_slot", cap[i], a5_slots[i/CPB]);
        // three back-to-back frames
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h80, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        idle(125);
        // overflow during a frame in progress
        step(1'b1, 8'h5A, 1'b0);
        idle(10);
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0);
        chk("full_after6", full, 1'b1);
        chk("ovf_after6", ovf, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("ovf_clr", ovf, 1'b0);
        idle(210);
        // reset during data bit 3 of 0x3C with two bytes queued
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        idle(16);
        chk("pre_rst_busy", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_txd", txd, 1'b1);
        chk("midrst_empty", empty, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        q.delete();
        active = 0;
        m_ovf = 0;
        @(negedge clk);
        reset = 1'b0;
        idle(60);
        // write landing on the final stop-bit cycle
        step(1'b1, 8'hC3, 1'b0);
        idle(40);
        step(1'b1, 8'h96, 1'b0);
        chk("stop_end_idle", busy, 1'b0);
        idle(45);
        // random traffic including drops and clears
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 19) == 0, 8'($urandom), $urandom_range(0, 39) == 0);
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0);
        idle(6 * FL);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
